// File: rtl/mul_writeback_unit.sv
// Radix-2 shift-add multiplier (MUL / UMULH / SMULH) that drives the register-file write port.
// Optional MUL_EARLY_TERM_EN: leave CALC as soon as the remaining multiplier bits are all zero.
module mul_writeback_unit #(
    parameter int WIDTH      = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Start,
    input  logic [1:0]            Op,
    input  logic [WIDTH-1:0]      OpA,
    input  logic [WIDTH-1:0]      OpB,
    input  logic [REG_ADDR_W-1:0] Rd,
    output logic                  Busy,
    output logic                  Done,
    output logic [WIDTH-1:0]      BusW,
    output logic [REG_ADDR_W-1:0] RW,
    output logic                  RegWr
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t                  r_state;
    logic [2*WIDTH-1:0]      r_acc;
    logic [2*WIDTH-1:0]      r_mcand;
    logic [WIDTH-1:0]        r_mplier;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_neg;
    logic                    r_hi;
    logic [REG_ADDR_W-1:0]   r_rd;

    logic                    w_signed;
    logic [WIDTH-1:0]        w_opa_ld;
    logic [WIDTH-1:0]        w_opb_ld;
    logic [2*WIDTH-1:0]      w_acc_sum;
    logic [WIDTH-1:0]        w_mplier_sh;
    logic                    w_calc_last;
    logic [2*WIDTH-1:0]      w_acc_fix;

    // SMULH multiplies magnitudes; the sign is restored in FIX.
    assign w_signed    = (Op == 2'b10);
    assign w_opa_ld    = (w_signed && OpA[WIDTH-1]) ? -OpA : OpA;
    assign w_opb_ld    = (w_signed && OpB[WIDTH-1]) ? -OpB : OpB;
    assign w_acc_sum   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mplier_sh = r_mplier >> 1;
    assign w_acc_fix   = r_neg ? -r_acc : r_acc;

`ifdef MUL_EARLY_TERM_EN
    assign w_calc_last = (r_cnt == CNT_W'(WIDTH-1)) || (w_mplier_sh == '0);
`else
    assign w_calc_last = (r_cnt == CNT_W'(WIDTH-1));
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_hi     <= 1'b0;
            r_rd     <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            BusW     <= '0;
            RW       <= '0;
            RegWr    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_hi     <= (Op == 2'b01) || (Op == 2'b10);
                        r_neg    <= w_signed && (OpA[WIDTH-1] ^ OpB[WIDTH-1]);
                        r_rd     <= Rd;
                        r_mcand  <= {{WIDTH{1'b0}}, w_opa_ld};
                        r_mplier <= w_opb_ld;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        Busy     <= 1'b1;
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc    <= w_acc_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_sh;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_calc_last) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    // Result is registered here so it is stable for the whole DONE cycle.
                    r_acc   <= w_acc_fix;
                    BusW    <= r_hi ? w_acc_fix[2*WIDTH-1:WIDTH] : w_acc_fix[WIDTH-1:0];
                    RW      <= r_rd;
                    RegWr   <= (r_rd != ZERO_REG);
                    Done    <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    Done    <= 1'b0;
                    RegWr   <= 1'b0;
                    Busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
